// File: rtl/pcs_cs_pkg.sv
// Shared types and helpers for the multi-channel 1000BASE-X PCS carrier-sense block.
package pcs_cs_pkg;

  // Hold-counter width; HOLD_CYC is limited to 0..255 so 8 bits always suffice.
  localparam int unsigned HCNT_W = 8;

  // Per-channel carrier-sense FSM state, 2-bit encoding.
  typedef logic [1:0] cs_state_t;

  localparam cs_state_t CS_IDLE = 2'd0;
  localparam cs_state_t CS_ON   = 2'd1;
  localparam cs_state_t CS_HOLD = 2'd2;

  // Carrier is sensed on receive activity, or on transmit activity unless acting as a repeater.
  function automatic logic cs_sense(input logic receiving,
                                    input logic transmitting,
                                    input logic repeater_mode);
    return receiving | (transmitting & ~repeater_mode);
  endfunction

endpackage

// File: rtl/pcs_carrier_sense_mp_if.sv
// Bus interface for pcs_carrier_sense_mp: PCS TX/RX activity in, GMII CRS/COL and counters out.
interface pcs_carrier_sense_mp_if #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CNT_W = 8
);

  logic                    repeater_mode;
  logic [N_CH-1:0]         transmitting;
  logic [N_CH-1:0]         receiving;
  logic [N_CH-1:0]         CRS;
  logic [N_CH-1:0]         COL;
  logic                    crs_any;
  logic [N_CH*CNT_W-1:0]   evt_cnt;

  // Driver side: the PCS state machines.
  modport master (
    output repeater_mode,
    output transmitting,
    output receiving,
    input  CRS,
    input  COL,
    input  crs_any,
    input  evt_cnt
  );

  // Carrier-sense block side.
  modport slave (
    input  repeater_mode,
    input  transmitting,
    input  receiving,
    output CRS,
    output COL,
    output crs_any,
    output evt_cnt
  );

endinterface

// File: rtl/pcs_cs_channel.sv
// One carrier-sense channel: IDLE/ON/HOLD FSM with deassertion hold, registered collision flag
// and, when CS_EVENT_CNT_EN is defined, a saturating carrier-event counter.
module pcs_cs_channel
  import pcs_cs_pkg::*;
#(
  parameter int unsigned HOLD_CYC = 2,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_repeater_mode,
  input  logic             i_transmitting,
  input  logic             i_receiving,
  output logic             o_crs,
  output logic             o_col,
  output logic [CNT_W-1:0] o_evt_cnt
);

  // The counter is loaded with HOLD_CYC-1 so that CRS drops exactly HOLD_CYC edges after sense.
  localparam int unsigned         HoldM1   = (HOLD_CYC > 0) ? HOLD_CYC - 1 : 0;
  localparam logic [HCNT_W-1:0]   HoldLoad = HoldM1[HCNT_W-1:0];

  logic              w_sense;
  cs_state_t         r_state;
  cs_state_t         w_state_nxt;
  logic [HCNT_W-1:0] r_hcnt;
  logic [HCNT_W-1:0] w_hcnt_nxt;
  logic              r_col;

  assign w_sense = cs_sense(i_receiving, i_transmitting, i_repeater_mode);

  // Next-state and hold-counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_hcnt_nxt  = r_hcnt;
    case (r_state)
      CS_IDLE: begin
        if (w_sense) w_state_nxt = CS_ON;
      end
      CS_ON: begin
        if (!w_sense) begin
          if (HOLD_CYC == 0) begin
            w_state_nxt = CS_IDLE;
          end else begin
            w_state_nxt = CS_HOLD;
            w_hcnt_nxt  = HoldLoad;
          end
        end
      end
      CS_HOLD: begin
        // Re-sense during hold continues the same carrier event.
        if (w_sense) begin
          w_state_nxt = CS_ON;
        end else if (r_hcnt == '0) begin
          w_state_nxt = CS_IDLE;
        end else begin
          w_hcnt_nxt = r_hcnt - HCNT_W'(1);
        end
      end
      default: w_state_nxt = CS_IDLE;
    endcase
  end

  // State, hold counter and collision registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= CS_IDLE;
      r_hcnt  <= '0;
      r_col   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hcnt  <= w_hcnt_nxt;
      r_col   <= i_transmitting & i_receiving & ~i_repeater_mode;
    end
  end

  assign o_crs = (r_state != CS_IDLE);
  assign o_col = r_col;

`ifdef CS_EVENT_CNT_EN
  logic             w_evt_start;
  logic [CNT_W-1:0] r_evt_cnt;

  // Only a fresh IDLE->ON start counts; HOLD->ON is the same event.
  assign w_evt_start = (r_state == CS_IDLE) & w_sense;

  // Saturating carrier-event counter, cleared only by reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_evt_cnt <= '0;
    end else if (w_evt_start && (r_evt_cnt != '1)) begin
      r_evt_cnt <= r_evt_cnt + CNT_W'(1);
    end
  end

  assign o_evt_cnt = r_evt_cnt;
`else
  assign o_evt_cnt = '0;
`endif

endmodule

// File: rtl/pcs_carrier_sense_mp.sv
// Multi-channel 1000BASE-X PCS carrier sense: N_CH independent CRS/COL channels plus crs_any.
// Optional per-channel carrier-event counters are built only when CS_EVENT_CNT_EN is defined;
// otherwise evt_cnt reads 0. The port list is the same in both builds.
module pcs_carrier_sense_mp
  import pcs_cs_pkg::*;
#(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned HOLD_CYC = 2,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                 CLOCK,
  input  logic                 mr_main_reset,
  pcs_carrier_sense_mp_if.slave bus
);

  logic [N_CH-1:0]       w_crs;
  logic [N_CH-1:0]       w_col;
  logic [N_CH*CNT_W-1:0] w_evt_cnt;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pcs_cs_channel #(
      .HOLD_CYC (HOLD_CYC),
      .CNT_W    (CNT_W)
    ) u_ch (
      .i_clk           (CLOCK),
      .i_rst           (mr_main_reset),
      .i_repeater_mode (bus.repeater_mode),
      .i_transmitting  (bus.transmitting[g]),
      .i_receiving     (bus.receiving[g]),
      .o_crs           (w_crs[g]),
      .o_col           (w_col[g]),
      .o_evt_cnt       (w_evt_cnt[g*CNT_W +: CNT_W])
    );
  end

  assign bus.CRS     = w_crs;
  assign bus.COL     = w_col;
  assign bus.crs_any = |w_crs;
  assign bus.evt_cnt = w_evt_cnt;

endmodule

// File: tb/tb_pcs_carrier_sense_mp.sv
// Directed bench for pcs_carrier_sense_mp. Four DUTs share one stimulus:
// A (HOLD_CYC=2), B (HOLD_CYC=0), C (HOLD_CYC=3), D (HOLD_CYC=2, CNT_W=2).
module tb_pcs_carrier_sense_mp;

`ifdef CS_EVENT_CNT_EN
  localparam bit CntOn = 1'b1;
`else
  localparam bit CntOn = 1'b0;
`endif

  logic       CLOCK = 1'b0;
  logic       rst   = 1'b1;
  logic       rm    = 1'b0;
  logic [3:0] tx    = 4'h0;
  logic [3:0] rx    = 4'hF;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLOCK = ~CLOCK;

  pcs_carrier_sense_mp_if #(.N_CH(4), .CNT_W(8)) if_a ();
  pcs_carrier_sense_mp_if #(.N_CH(4), .CNT_W(8)) if_b ();
  pcs_carrier_sense_mp_if #(.N_CH(4), .CNT_W(8)) if_c ();
  pcs_carrier_sense_mp_if #(.N_CH(4), .CNT_W(2)) if_d ();

  assign if_a.repeater_mode = rm;
  assign if_a.transmitting  = tx;
  assign if_a.receiving     = rx;
  assign if_b.repeater_mode = rm;
  assign if_b.transmitting  = tx;
  assign if_b.receiving     = rx;
  assign if_c.repeater_mode = rm;
  assign if_c.transmitting  = tx;
  assign if_c.receiving     = rx;
  assign if_d.repeater_mode = rm;
  assign if_d.transmitting  = tx;
  assign if_d.receiving     = rx;

  pcs_carrier_sense_mp #(.N_CH(4), .HOLD_CYC(2), .CNT_W(8)) u_dut_a (
    .CLOCK         (CLOCK),
    .mr_main_reset (rst),
    .bus           (if_a)
  );

  pcs_carrier_sense_mp #(.N_CH(4), .HOLD_CYC(0), .CNT_W(8)) u_dut_b (
    .CLOCK         (CLOCK),
    .mr_main_reset (rst),
    .bus           (if_b)
  );

  pcs_carrier_sense_mp #(.N_CH(4), .HOLD_CYC(3), .CNT_W(8)) u_dut_c (
    .CLOCK         (CLOCK),
    .mr_main_reset (rst),
    .bus           (if_c)
  );

  pcs_carrier_sense_mp #(.N_CH(4), .HOLD_CYC(2), .CNT_W(2)) u_dut_d (
    .CLOCK         (CLOCK),
    .mr_main_reset (rst),
    .bus           (if_d)
  );

  typedef struct {
    logic       rst;
    logic       rm;
    logic [3:0] tx;
    logic [3:0] rx;
    logic [3:0] crs;     // expected CRS of DUT A (hold 2)
    logic [3:0] col;     // expected COL of DUT A
    logic [3:0] crs_h0;  // expected CRS of DUT B (no hold)
  } vec_t;

  localparam int NVec = 22;
  vec_t vecs[NVec];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply inputs, clock one edge, then sample 1 time unit after the edge.
  task automatic step(input logic r, input logic m, input logic [3:0] t, input logic [3:0] x);
    rst = r;
    rm  = m;
    tx  = t;
    rx  = x;
    @(posedge CLOCK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //            rst   rm    tx    rx     crs   col   crs_h0
    vecs[0]  = '{1'b1, 1'b0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0};
    vecs[1]  = '{1'b1, 1'b0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0};
    vecs[2]  = '{1'b0, 1'b0, 4'h0, 4'hF, 4'hF, 4'h0, 4'hF};
    vecs[3]  = '{1'b0, 1'b0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0};
    vecs[4]  = '{1'b0, 1'b0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0};
    vecs[5]  = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[6]  = '{1'b0, 1'b1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[7]  = '{1'b0, 1'b1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[8]  = '{1'b0, 1'b0, 4'h2, 4'h0, 4'h2, 4'h0, 4'h2};
    vecs[9]  = '{1'b0, 1'b0, 4'h4, 4'h4, 4'h6, 4'h4, 4'h4};
    vecs[10] = '{1'b0, 1'b0, 4'h4, 4'h0, 4'h6, 4'h0, 4'h4};
    vecs[11] = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0};
    vecs[12] = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0};
    vecs[13] = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[14] = '{1'b0, 1'b0, 4'h8, 4'h0, 4'h8, 4'h0, 4'h8};
    vecs[15] = '{1'b0, 1'b1, 4'h8, 4'h0, 4'h8, 4'h0, 4'h0};
    vecs[16] = '{1'b0, 1'b1, 4'h8, 4'h0, 4'h8, 4'h0, 4'h0};
    vecs[17] = '{1'b0, 1'b1, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[18] = '{1'b0, 1'b1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h1};
    vecs[19] = '{1'b0, 1'b0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1};
    vecs[20] = '{1'b1, 1'b0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0};
    vecs[21] = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};

    for (int i = 0; i < NVec; i++) begin
      step(vecs[i].rst, vecs[i].rm, vecs[i].tx, vecs[i].rx);
      chk($sformatf("v%0d_crs", i), 32'(if_a.CRS), 32'(vecs[i].crs));
      chk($sformatf("v%0d_col", i), 32'(if_a.COL), 32'(vecs[i].col));
      chk($sformatf("v%0d_crs_any", i), 32'(if_a.crs_any), 32'(|vecs[i].crs));
      chk($sformatf("v%0d_crs_h0", i), 32'(if_b.CRS), 32'(vecs[i].crs_h0));
      if (vecs[i].rst) chk($sformatf("v%0d_rst_evt", i), if_a.evt_cnt, 32'h0);
    end

    // Re-sense during hold on channel 3 of DUT C (hold 3): one continuous carrier event.
    step(1'b0, 1'b0, 4'h0, 4'h8);
    chk("c_rise", 32'(if_c.CRS[3]), 32'd1);
    step(1'b0, 1'b0, 4'h0, 4'h0);
    chk("c_gap", 32'(if_c.CRS[3]), 32'd1);
    step(1'b0, 1'b0, 4'h0, 4'h8);
    chk("c_resense", 32'(if_c.CRS[3]), 32'd1);
    chk("c_evt1", 32'(if_c.evt_cnt[24 +: 8]), CntOn ? 32'd1 : 32'd0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 4'h0, 4'h0);
      chk($sformatf("c_hold%0d", k), 32'(if_c.CRS[3]), 32'd1);
    end
    step(1'b0, 1'b0, 4'h0, 4'h0);
    chk("c_drop", 32'(if_c.CRS[3]), 32'd0);
    step(1'b0, 1'b0, 4'h0, 4'h8);
    chk("c_rise2", 32'(if_c.CRS[3]), 32'd1);
    chk("c_evt2", 32'(if_c.evt_cnt[24 +: 8]), CntOn ? 32'd2 : 32'd0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 4'h0, 4'h0);

    // Five separated events on channel 0 of DUT D (2-bit counter) saturate at 3.
    for (int e = 0; e < 5; e++) begin
      step(1'b0, 1'b0, 4'h0, 4'h1);
      step(1'b0, 1'b0, 4'h0, 4'h0);
      step(1'b0, 1'b0, 4'h0, 4'h0);
      step(1'b0, 1'b0, 4'h0, 4'h0);
      chk($sformatf("d_idle%0d", e), 32'(if_d.CRS[0]), 32'd0);
      if (e == 1) chk("d_evt2", 32'(if_d.evt_cnt[1:0]), CntOn ? 32'd2 : 32'd0);
    end
    chk("d_evt_sat", 32'(if_d.evt_cnt[1:0]), CntOn ? 32'd3 : 32'd0);

    // Reset while channel 0 is in hold.
    step(1'b0, 1'b0, 4'h0, 4'h1);
    step(1'b0, 1'b0, 4'h0, 4'h0);
    chk("d_in_hold", 32'(if_d.CRS[0]), 32'd1);
    step(1'b1, 1'b0, 4'h0, 4'h0);
    chk("d_rst_crs", 32'(if_d.CRS[0]), 32'd0);
    chk("d_rst_evt", 32'(if_d.evt_cnt), 32'd0);
    chk("d_rst_any", 32'(if_d.crs_any), 32'd0);
    step(1'b0, 1'b0, 4'h0, 4'h0);
    chk("d_post_crs", 32'(if_d.CRS[0]), 32'd0);
    chk("d_post_evt", 32'(if_d.evt_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pcs_carrier_sense_mp.md
Name: pcs_carrier_sense_mp

Overview:
- Multi-channel carrier-sense block for the 1000BASE-X PCS, clause 36.
- Generalises the single-channel CRS function to N_CH independent channels.
- Each channel has registered CRS with a programmable deassertion hold, plus a registered per-channel collision flag.
- Sits between the per-port PCS transmit/receive state machines and the GMII CRS/COL outputs.

Parameters:
N_CH, 4, number of independent channels (1..16)
HOLD_CYC, 2, extra cycles CRS stays high after the sense condition drops (0 = no hold; 0..255)
CNT_W, 8, width of each per-channel carrier-event counter (only meaningful with CS_EVENT_CNT_EN)

Ports:
CLOCK  input  1  single clock, all logic on rising edge
mr_main_reset  input  1  reset, synchronous and active-high
repeater_mode  input  1  global; 1 = transmit activity does not raise CRS
transmitting  input  N_CH  per-channel transmitting flag from the PCS TX state machine
receiving  input  N_CH  per-channel receiving flag from the PCS RX state machine
CRS  output  N_CH  registered per-channel carrier sense
COL  output  N_CH  registered per-channel collision
crs_any  output  1  OR-reduction of CRS
evt_cnt  output  N_CH*CNT_W  per-channel carrier-event counters; channel i occupies bits [i*CNT_W +: CNT_W]

Behaviour:
- Sense term: sense[i] = receiving[i] | (transmitting[i] & ~repeater_mode). All inputs are sampled at every rising CLOCK edge.
- Reset: while mr_main_reset=1 at an edge, every channel goes to CS_IDLE and the hold counter clears. After that edge CRS=0, COL=0, crs_any=0 and evt_cnt=0. Reset overrides all other events, including mid-hold and mid-carrier.
- Per-channel FSM, with states CS_IDLE, CS_ON and CS_HOLD:
  - CS_IDLE: if sense, go to CS_ON. CRS=0.
  - CS_ON: if ~sense and HOLD_CYC=0, go to CS_IDLE. If ~sense and HOLD_CYC>0, go to CS_HOLD and load hcnt=HOLD_CYC-1. Otherwise stay. CRS=1.
  - CS_HOLD: if sense, go to CS_ON (same carrier event). Else if hcnt=0, go to CS_IDLE. Else decrement hcnt. CRS=1.
- CRS is a state decode of a register. Latency from sense rise to CRS rise is 1 cycle.
- When sense falls at edge t, CRS stays 1 after edges t..t+HOLD_CYC-1 and reads 0 after edge t+HOLD_CYC.
- hcnt width is 8 bits. It never wraps, because it only decrements while nonzero.
- COL[i] is registered: transmitting[i] & receiving[i] & ~repeater_mode. Latency is 1 cycle; no hold is applied.
- crs_any is combinational OR of the CRS registers, so it is valid in the same cycle as CRS.
- A repeater_mode change affects sense and COL from the next edge. A channel in CS_ON whose sense drops because repeater_mode rose enters CS_HOLD normally.
- Channels are fully independent. Simultaneous events on different channels never interact.

Optional Feature:
- Macro: CS_EVENT_CNT_EN.
- Defined: evt_cnt[i] increments by 1 on every CS_IDLE->CS_ON transition. A CS_HOLD->CS_ON transition does not count. The counter saturates at 2^CNT_W-1 and is cleared only by mr_main_reset.
- Undefined: no counter logic is built and evt_cnt is tied to 0. The port list is identical in both builds.

Decomposition:
- Package pcs_cs_pkg holds:
  - the state typedef for CS_IDLE/CS_ON/CS_HOLD, with a 2-bit encoding;
  - localparam HCNT_W=8;
  - the sense-term function.
- Sub-module pcs_cs_channel implements one channel: FSM, hold counter, COL register and optional counter.
- The top level generates N_CH instances and the crs_any reduction.

Test Plan:
- Reset: hold mr_main_reset=1 for 2 cycles with receiving=4'hF -> CRS=0, COL=0, evt_cnt=0. CRS[3:0]=4'hF 1 cycle after release.
- Hold timing, HOLD_CYC=2: receiving[0] high for 5 cycles then low at edge t -> CRS[0] rises 1 cycle after assertion, stays 1 through edge t+1, is 0 after edge t+2. With HOLD_CYC=0, CRS[0]=0 after edge t.
- Repeater mode: repeater_mode=1, transmitting[1]=1, receiving[1]=0 -> CRS[1]=0 and COL[1]=0 indefinitely. Set repeater_mode=0 -> CRS[1]=1 next cycle.
- Collision: transmitting[2]=receiving[2]=1, repeater_mode=0 -> COL[2]=1 after 1 edge. Drop receiving[2] -> COL[2]=0 after the next edge while CRS[2] stays 1.
- Re-sense during hold (CS_EVENT_CNT_EN, HOLD_CYC=3): receiving[3] pulses 1-0-1 with a 1-cycle gap -> CRS[3] stays continuously 1 and evt_cnt[3]=1. A pulse after CRS has returned to 0 gives evt_cnt[3]=2.
- Saturation and reset mid-hold (CNT_W=2): 5 separated carrier events -> evt_cnt[0]=3. Assert reset while channel 0 is in CS_HOLD -> CRS[0]=0 and evt_cnt[0]=0 after that edge.
